player_input_ctrl: RTL and testbench

// - Upstream of the player control FSM: turns raw active-low push buttons into clean single-cycle p_up/p_down requests.
// - Synchronises and debounces both keys, divides the system clock into a 60 Hz frame tick, and issues at most one move request per frame.
// - This spacing keeps requests outside the player FSM's 7-cycle draw sequence (WAIT plus six draw states).

---
 rtl/player_input_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_player_input_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_input_ctrl.sv
// -----------------------------------------------------------------------------
// player_input_ctrl
//
// Front end for the player control FSM. Two raw, active-low push buttons are
// synchronised, debounced and turned into clean one-cycle p_up / p_down move
// requests. A frame divider produces a frame_tick pulse. At most one request is
// issued per frame, so requests never land inside the player FSM's multi-cycle
// draw sequence.
//
// Configuration:
//   PLAYER_AUTOREPEAT_EN  when defined, a held key auto-repeats after
//                         INITIAL_DELAY_FRAMES frames, then every REPEAT_FRAMES
//                         frames. When undefined, each press gives exactly one
//                         request and no repeat counter is built.
//
// Parameters:
//   FRAME_DIV             system clocks per frame tick (>= 8)
//   DEBOUNCE_CYCLES       consecutive stable cycles before a key change counts
//   INITIAL_DELAY_FRAMES  frames held before the first auto-repeat
//   REPEAT_FRAMES         frames between later auto-repeats
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   key_up_n    in   raw up button, active-low, asynchronous to clk
//   key_down_n  in   raw down button, active-low, asynchronous to clk
//   enable      in   1 = accept input, 0 = force IDLE and suppress requests
//   p_up        out  one-cycle up request
//   p_down      out  one-cycle down request
//   frame_tick  out  one-cycle pulse every FRAME_DIV clocks
// -----------------------------------------------------------------------------
module player_input_ctrl #(
  parameter int FRAME_DIV            = 833333,
  parameter int DEBOUNCE_CYCLES      = 250000,
  parameter int INITIAL_DELAY_FRAMES = 15,
  parameter int REPEAT_FRAMES        = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_up_n,
  input  logic key_down_n,
  input  logic enable,
  output logic p_up,
  output logic p_down,
  output logic frame_tick
);

  localparam int DIV_W = $clog2(FRAME_DIV);
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // waiting for a press edge
    S_PEND = 2'd1,  // key accepted, waiting for the next frame tick
    S_FIRE = 2'd2,  // request pulse is on the outputs this cycle
    S_HOLD = 2'd3   // key still held after a request
  } state_t;

  // Doubles as the bit index into the per-key vectors (bit 0 = up, bit 1 = down).
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // ---------------------------------------------------------------------------
  // Synchroniser: two flops per key, stored active-high (1 = pressed).
  // ---------------------------------------------------------------------------
  logic [1:0] key_raw;
  logic [1:0] sync_meta;
  logic [1:0] sync_key;

  assign key_raw = {~key_down_n, ~key_up_n};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_key  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so sync_key really is two stages behind key_raw; blocking
      // assignments here would collapse the chain into a single stage.
      sync_meta <= key_raw;
      sync_key  <= sync_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: a key's accepted state flips only after the synchronised value
  // has disagreed with it for DEBOUNCE_CYCLES consecutive cycles. Any cycle of
  // agreement restarts the count, so bounce shorter than that is ignored.
  // ---------------------------------------------------------------------------
  logic [DEB_W-1:0] deb_cnt [2];
  logic [1:0]       deb_key;
  logic [1:0]       deb_key_q;
  logic [1:0]       press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
      deb_key   <= '0;
      deb_key_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_key[i] != deb_key[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_key[i] <= sync_key[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
      deb_key_q <= deb_key;
    end
  end

  // A press is the debounced 0->1 transition, visible for exactly one cycle.
  assign press = deb_key & ~deb_key_q;

  // ---------------------------------------------------------------------------
  // Frame divider. Free-running: enable does not stop it, so the frame grid
  // stays aligned to reset no matter how input is gated.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      frame_tick <= (div_cnt == DIV_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  state_t state;
  dir_t   dir;
  logic   dir_held;

  // Debounced level of the key that owns the current request.
  assign dir_held = deb_key[dir];

`ifdef PLAYER_AUTOREPEAT_EN
  localparam int RPT_MAX = (INITIAL_DELAY_FRAMES > REPEAT_FRAMES) ?
                           INITIAL_DELAY_FRAMES : REPEAT_FRAMES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(INITIAL_DELAY_FRAMES);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_FRAMES);

  // Frame ticks counted in HOLD since the last request. rpt_first selects the
  // longer initial delay until the first auto-repeat has gone out.
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;
  logic [RPT_W-1:0] rpt_next;
  logic             rpt_due;

  assign rpt_next = rpt_cnt + 1'b1;
  assign rpt_due  = (rpt_next == (rpt_first ? RPT_FIRST : RPT_NEXT));
`else
  // The repeat timing parameters are kept for interface compatibility; with
  // auto-repeat compiled out they select no hardware.
  if (INITIAL_DELAY_FRAMES < 0 || REPEAT_FRAMES < 0) begin : g_repeat_params_unused
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      dir       <= DIR_UP;
      p_up      <= 1'b0;
      p_down    <= 1'b0;
`ifdef PLAYER_AUTOREPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
`endif
    end else begin
      // Requests are single-cycle: only the transition into S_FIRE raises them.
      p_up   <= 1'b0;
      p_down <= 1'b0;

      if (!enable) begin
        // Gating drops any pending request; a pulse already on the outputs
        // still finishes its one cycle because it was registered last edge.
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            // Simultaneous presses of both keys cancel each other.
            if (press[0] ^ press[1]) begin
              dir   <= press[1] ? DIR_DOWN : DIR_UP;
              state <= S_PEND;
            end
          end

          S_PEND: begin
            if (!dir_held) begin
              state <= S_IDLE;
            end else if (frame_tick) begin
              state  <= S_FIRE;
              p_up   <= (dir == DIR_UP);
              p_down <= (dir == DIR_DOWN);
`ifdef PLAYER_AUTOREPEAT_EN
              rpt_first <= 1'b1;
`endif
            end
          end

          S_FIRE: begin
            // frame_tick cannot recur here, since the tick that fired was the
            // previous cycle and FRAME_DIV >= 8.
            state <= S_HOLD;
`ifdef PLAYER_AUTOREPEAT_EN
            rpt_cnt <= '0;
`endif
          end

          S_HOLD: begin
            // Release is checked first so it wins over a repeat on the same tick.
            if (!dir_held) begin
              state <= S_IDLE;
            end
`ifdef PLAYER_AUTOREPEAT_EN
            else if (frame_tick) begin
              if (rpt_due) begin
                state     <= S_FIRE;
                p_up      <= (dir == DIR_UP);
                p_down    <= (dir == DIR_DOWN);
                rpt_first <= 1'b0;
              end else begin
                rpt_cnt <= rpt_next;
              end
            end
`endif
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_input_ctrl
//
// Self-checking bench for player_input_ctrl with small timing parameters.
// A behavioural model tracks key history, debounced levels, the frame grid and
// request ownership, and is compared with the DUT every cycle. Directed
// scenarios (reset, single press, bounce, conflict, enable gating) are
// followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_player_input_ctrl;

  localparam int FD   = 10;
  localparam int DEB  = 4;
  localparam int INIT = 3;
  localparam int REP  = 2;

  logic clk        = 1'b0;
  logic reset_n    = 1'b1;
  logic key_up_n   = 1'b1;
  logic key_down_n = 1'b1;
  logic enable     = 1'b1;
  logic p_up;
  logic p_down;
  logic frame_tick;

  always #5 clk = ~clk;

  player_input_ctrl #(
    .FRAME_DIV           (FD),
    .DEBOUNCE_CYCLES     (DEB),
    .INITIAL_DELAY_FRAMES(INIT),
    .REPEAT_FRAMES       (REP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_up_n   (key_up_n),
    .key_down_n (key_down_n),
    .enable     (enable),
    .p_up       (p_up),
    .p_down     (p_down),
    .frame_tick (frame_tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit [1:0] m_hist1, m_hist2;   // pressed levels seen one and two edges ago
  bit [1:0] m_deb, m_deb_prev;  // accepted key levels, now and one cycle ago
  int       m_run [2];          // consecutive cycles of disagreement per key
  int       m_k;                // edges since reset release
  bit       m_tick;
  int       m_owner;            // -1 none, 0 up, 1 down
  int       m_n;                // frame ticks seen while owned
  bit       m_just;             // the cycle right after a request
  bit       m_pu, m_pd;

  function automatic bit fire_due(input int n);
`ifdef PLAYER_AUTOREPEAT_EN
    int since;
    since = n - 1;
    return (n == 1) || (since == INIT) || (since > INIT && (since - INIT) % REP == 0);
`else
    return n == 1;
`endif
  endfunction

  task automatic model_reset();
    m_hist1 = '0; m_hist2 = '0; m_deb = '0; m_deb_prev = '0;
    m_run[0] = 0; m_run[1] = 0;
    m_k = 0; m_tick = 0;
    m_owner = -1; m_n = 0; m_just = 0;
    m_pu = 0; m_pd = 0;
  endtask

  task automatic model_edge();
    bit [1:0] pdeb, pedge, synced, raw;
    bit       ptick;
    pdeb   = m_deb;
    pedge  = m_deb & ~m_deb_prev;
    synced = m_hist2;
    ptick  = m_tick;
    raw    = {~key_down_n, ~key_up_n};

    m_pu = 0;
    m_pd = 0;
    if (!enable) begin
      m_owner = -1;
      m_just  = 0;
    end else if (m_just) begin
      m_just = 0;
    end else if (m_owner < 0) begin
      if (pedge == 2'b01) begin m_owner = 0; m_n = 0; end
      else if (pedge == 2'b10) begin m_owner = 1; m_n = 0; end
    end else if (!pdeb[m_owner]) begin
      m_owner = -1;
    end else if (ptick) begin
      m_n++;
      if (fire_due(m_n)) begin
        m_pu   = (m_owner == 0);
        m_pd   = (m_owner == 1);
        m_just = 1;
      end
    end

    for (int i = 0; i < 2; i++) begin
      if (synced[i] != pdeb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_deb[i] = ~m_deb[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_deb_prev = pdeb;
    m_hist2    = m_hist1;
    m_hist1    = raw;
    m_k++;
    m_tick = (m_k % FD == 0);
  endtask

  // ---------------------------------------------------------------------------
  // Cycle stepping with per-cycle comparison
  // ---------------------------------------------------------------------------
  int cyc      = 0;
  int last_req = -1;
  int cnt_up   = 0;
  int cnt_dn   = 0;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("p_up", p_up, m_pu);
    check("p_down", p_down, m_pd);
    check("frame_tick", frame_tick, m_tick);
    check("p_exclusive", p_up & p_down, 1'b0);
    if (p_up || p_down) begin
      if (last_req >= 0) check("req_gap", (cyc - last_req) >= FD, 1'b1);
      last_req = cyc;
    end
    if (p_up)   cnt_up++;
    if (p_down) cnt_dn++;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic apply_reset(input int hold_cycles);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_p_up", p_up, 1'b0);
    check("rst_p_down", p_down, 1'b0);
    check("rst_frame_tick", frame_tick, 1'b0);
    model_reset();
    last_req = -1;
    repeat (hold_cycles) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic clear_counts();
    cnt_up = 0;
    cnt_dn = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit found;

    apply_reset(3);

    // Frame tick spacing from reset release.
    t = 0; found = 0;
    for (int i = 0; i < 3 * FD; i++) begin
      step(); t++;
      if (frame_tick) begin found = 1; break; end
    end
    check("first_tick_cycle", found ? t : 0, FD);
    t = 0; found = 0;
    for (int i = 0; i < 3 * FD; i++) begin
      step(); t++;
      if (frame_tick) begin found = 1; break; end
    end
    check("tick_period", found ? t : 0, FD);

    // Single press.
    run(5);
    clear_counts();
    key_up_n = 1'b0;
    run(60);
    key_up_n = 1'b1;
    run(20);
`ifdef PLAYER_AUTOREPEAT_EN
    check("single_up_some", cnt_up > 0, 1'b1);
`else
    check("single_up_count", cnt_up, 1);
`endif
    check("single_down_count", cnt_dn, 0);

    // Bounce on the down key never settles long enough to be accepted.
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      key_down_n = 1'b0; run(2);
      key_down_n = 1'b1; run(2);
    end
    run(20);
    check("bounce_down_count", cnt_dn, 0);
    key_down_n = 1'b0; run(6);
    key_down_n = 1'b1; run(25);

    // Both keys pressed together cancel.
    clear_counts();
    key_up_n = 1'b0; key_down_n = 1'b0;
    run(50);
    check("conflict_up", cnt_up, 0);
    check("conflict_down", cnt_dn, 0);
    key_up_n = 1'b1; key_down_n = 1'b1;
    run(20);

    // Up first, down three cycles later: down is ignored.
    clear_counts();
    key_up_n = 1'b0; run(3);
    key_down_n = 1'b0; run(40);
    key_up_n = 1'b1; key_down_n = 1'b1;
    run(20);
`ifdef PLAYER_AUTOREPEAT_EN
    check("seq_up_some", cnt_up > 0, 1'b1);
`else
    check("seq_up_count", cnt_up, 1);
`endif
    check("seq_down_count", cnt_dn, 0);

    // enable=0 while a request is pending, then re-enable with the key held.
    found = 0;
    for (int i = 0; i < 2 * FD; i++) begin
      step();
      if (frame_tick) begin found = 1; break; end
    end
    check("en_tick_seen", found, 1'b1);
    clear_counts();
    key_up_n = 1'b0; run(8);
    enable = 1'b0;   run(20);
    enable = 1'b1;   run(40);
    check("en_drop_up", cnt_up, 0);
    key_up_n = 1'b1; run(20);
    clear_counts();
    key_up_n = 1'b0; run(30);
    key_up_n = 1'b1; run(20);
`ifdef PLAYER_AUTOREPEAT_EN
    check("en_repress_some", cnt_up > 0, 1'b1);
`else
    check("en_repress_count", cnt_up, 1);
`endif

    // Auto-repeat cadence (or single request) for a long hold.
    clear_counts();
    key_up_n = 1'b0; run(120);
    key_up_n = 1'b1; run(20);
    check("long_hold_down", cnt_dn, 0);
`ifndef PLAYER_AUTOREPEAT_EN
    check("long_hold_up", cnt_up, 1);
`endif

    // Reset while a request is on the outputs.
    found = 0;
    key_down_n = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (p_down) begin found = 1; break; end
    end
    check("mid_req_seen", found, 1'b1);
    key_down_n = 1'b1;
    apply_reset(2);
    run(20);

    // Randomized run.
    for (int s = 0; s < 400; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        key_up_n = ~key_up_n;
      end else if (r < 7) begin
        key_down_n = ~key_down_n;
      end else if (r == 7) begin
        int nb;
        nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) begin
          key_down_n = ~key_down_n;
          run($urandom_range(1, 3));
        end
      end else if (r == 8) begin
        if (!enable) enable = 1'b1;
        else if ($urandom_range(0, 2) == 0) enable = 1'b0;
      end else begin
        key_up_n   = ~key_up_n;
        key_down_n = ~key_down_n;
      end
      if (s == 200) apply_reset($urandom_range(1, 3));
      run($urandom_range(1, 40));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
